// File: rtl/crc_rx_seq.sv
// crc_rx_seq -- USB receive packet sequencer.
//
// Sits between the bit decoder and a pair of external CRC engines (CRC5 for
// tokens, CRC16 for data). Collects the PID byte, steers payload bits into the
// right engine, counts bits, and at end of packet reports length / PID / CRC
// errors plus a one-cycle completion pulse.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   sop                    start of packet (SYNC just completed)
//   bit_valid, bit_data    one decoded bit per strobe, LSB first
//   eop                    end-of-packet strobe
//   crc5_valid             CRC5 engine residual matches
//   crc16_valid            CRC16 engine residual matches
//   crc_data               bit presented to both engines (= bit_data)
//   crc_clear              preset both engines
//   crc5_shift             shift enable for the CRC5 engine
//   crc16_shift            shift enable for the CRC16 engine
//   pid[3:0]               PID nibble of the most recent packet
//   pkt_done               one-cycle pulse when a packet has been checked
//   pkt_ok                 packet passed every check (held until next sop)
//   err_pid/err_len/err_crc  error flags (held until next sop)
module crc_rx_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       sop,
  input  logic       bit_valid,
  input  logic       bit_data,
  input  logic       eop,
  input  logic       crc5_valid,
  input  logic       crc16_valid,
  output logic       crc_data,
  output logic       crc_clear,
  output logic       crc5_shift,
  output logic       crc16_shift,
  output logic [3:0] pid,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       err_pid,
  output logic       err_len,
  output logic       err_crc
);

  localparam int unsigned CNT_W = 11;

  // Bit counts include the 8 PID bits.
  localparam logic [CNT_W-1:0] TOKEN_BITS = 11'd24;
  localparam logic [CNT_W-1:0] HSK_BITS   = 11'd8;
  localparam logic [CNT_W-1:0] DATA_MIN   = 11'd24;
  localparam logic [CNT_W-1:0] DATA_MAX   = 11'd1048;
  localparam logic [CNT_W-1:0] PID_LAST   = 11'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOKEN,
    S_DATA,
    S_HSK,
    S_DRAIN,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  state_t           kind_q, kind_d;    // state the packet was in at eop
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pid_sr_q, pid_sr_d;
  logic [3:0]       pid_q, pid_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             err_pid_q, err_pid_d;
  logic             err_len_q, err_len_d;
  logic             err_crc_q, err_crc_d;
  logic             clr_pend_q;        // engines still need a preset after reset

  logic [7:0]       pid_byte;
  logic             len_bad;
  logic             crc_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 11'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    pid_sr_d    = pid_sr_q;
    pid_d       = pid_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = pkt_ok_q;
    err_pid_d   = err_pid_q;
    err_len_d   = err_len_q;
    err_crc_d   = err_crc_q;
    crc5_shift  = 1'b0;
    crc16_shift = 1'b0;
    pid_byte    = {bit_data, pid_sr_q[7:1]};
    len_bad     = 1'b0;
    crc_bad     = 1'b0;

    if (sop) begin
      // sop wins over everything, including a coincident eop; an aborted
      // packet never reaches CHECK so it never pulses pkt_done.
      state_d   = S_PID;
      cnt_d     = '0;
      pkt_ok_d  = 1'b0;
      err_pid_d = 1'b0;
      err_len_d = 1'b0;
      err_crc_d = 1'b0;
    end else begin
      case (state_q)
        S_PID: begin
          if (eop) begin
            kind_d  = S_PID;
            state_d = S_CHECK;
          end else if (bit_valid) begin
            cnt_d    = sat_inc(cnt_q);
            pid_sr_d = pid_byte;
            if (cnt_q == PID_LAST) begin
              pid_d = pid_byte[3:0];
              if (pid_byte[7:4] != ~pid_byte[3:0]) begin
                err_pid_d = 1'b1;
                state_d   = S_DRAIN;
              end else begin
                case (pid_byte[1:0])
                  2'b01:   state_d = S_TOKEN;
                  2'b11:   state_d = S_DATA;
                  2'b10:   state_d = S_HSK;
                  default: begin
                    err_pid_d = 1'b1;
                    state_d   = S_DRAIN;
                  end
                endcase
              end
            end
          end
        end
        S_TOKEN: begin
          if (eop) begin
            kind_d  = S_TOKEN;
            state_d = S_CHECK;
          end else if (bit_valid) begin
            cnt_d = sat_inc(cnt_q);
            // Overlong tokens are still counted but kept out of the engine.
            crc5_shift = (cnt_q < TOKEN_BITS);
          end
        end
        S_DATA: begin
          if (eop) begin
            kind_d  = S_DATA;
            state_d = S_CHECK;
          end else if (bit_valid) begin
            cnt_d       = sat_inc(cnt_q);
            crc16_shift = 1'b1;
          end
        end
        S_HSK: begin
          if (eop) begin
            kind_d  = S_HSK;
            state_d = S_CHECK;
          end else if (bit_valid) begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_DRAIN: begin
          if (eop) begin
            kind_d  = S_DRAIN;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          state_d    = S_IDLE;
          pkt_done_d = 1'b1;
          case (kind_q)
            S_TOKEN: begin
              len_bad = (cnt_q != TOKEN_BITS);
              crc_bad = !crc5_valid;
            end
            S_HSK: len_bad = (cnt_q != HSK_BITS);
            S_DATA: begin
              len_bad = (cnt_q < DATA_MIN) || (cnt_q > DATA_MAX) ||
                        (cnt_q[2:0] != 3'd0);
              crc_bad = !crc16_valid;
            end
            S_PID:   len_bad = 1'b1;
            default: len_bad = 1'b0;
          endcase
          // A CRC verdict on a packet of the wrong length is meaningless.
          if (len_bad) crc_bad = 1'b0;
          err_len_d = len_bad;
          err_crc_d = crc_bad;
          pkt_ok_d  = !(len_bad || crc_bad || err_pid_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= S_IDLE;
      cnt_q      <= '0;
      pid_q      <= '0;
      pkt_done_q <= 1'b0;
      pkt_ok_q   <= 1'b0;
      err_pid_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_crc_q  <= 1'b0;
      clr_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      pid_q      <= pid_d;
      pkt_done_q <= pkt_done_d;
      pkt_ok_q   <= pkt_ok_d;
      err_pid_q  <= err_pid_d;
      err_len_q  <= err_len_d;
      err_crc_q  <= err_crc_d;
      clr_pend_q <= 1'b0;
    end
  end

  // PID shift register is pure data; its contents only matter once 8 bits
  // have arrived after a sop.
  always_ff @(posedge clk) begin
    pid_sr_q <= pid_sr_d;
  end

  assign crc_data  = bit_data;
  assign crc_clear = (sop | clr_pend_q) & ~rst;
  assign pid       = pid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;
  assign err_pid   = err_pid_q;
  assign err_len   = err_len_q;
  assign err_crc   = err_crc_q;

endmodule

// File: tb/tb_crc_rx_seq.sv
module tb_crc_rx_seq;

  logic       clk = 1'b0;
  logic       rst, sop, bit_valid, bit_data, eop;
  logic       crc5_valid, crc16_valid;
  logic       crc_data, crc_clear, crc5_shift, crc16_shift;
  logic [3:0] pid;
  logic       pkt_done, pkt_ok, err_pid, err_len, err_crc;

  int n_checks = 0;
  int n_fail   = 0;

  crc_rx_seq dut (
    .clk         (clk),
    .rst         (rst),
    .sop         (sop),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .eop         (eop),
    .crc5_valid  (crc5_valid),
    .crc16_valid (crc16_valid),
    .crc_data    (crc_data),
    .crc_clear   (crc_clear),
    .crc5_shift  (crc5_shift),
    .crc16_shift (crc16_shift),
    .pid         (pid),
    .pkt_done    (pkt_done),
    .pkt_ok      (pkt_ok),
    .err_pid     (err_pid),
    .err_len     (err_len),
    .err_crc     (err_crc)
  );

  always #5 clk = ~clk;

  // USB CRC engine models: CRC5 poly x^5+x^2+1, CRC16 poly 0x8005, both
  // preset to all ones; a correct packet leaves the fixed USB residuals.
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;
  logic        fb5, fb16;
  assign fb5  = crc_data ^ crc5_q[4];
  assign fb16 = crc_data ^ crc16_q[15];
  always @(posedge clk) begin
    if (crc_clear) begin
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
    end else begin
      if (crc5_shift)  crc5_q  <= {crc5_q[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
      if (crc16_shift) crc16_q <= {crc16_q[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
    end
  end
  assign crc5_valid  = (crc5_q == 5'b01100);
  assign crc16_valid = (crc16_q == 16'h800D);

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  pid;
    logic        ok;
    logic        ep;
    logic        el;
    logic        ec;
    logic [15:0] n5;
    logic [15:0] n16;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input int id, input logic [3:0] p, input logic ok,
                              input logic ep, input logic el, input logic ec,
                              input int n5, input int n16);
    exp_t e;
    e.id  = id[7:0];
    e.pid = p;
    e.ok  = ok;
    e.ep  = ep;
    e.el  = el;
    e.ec  = ec;
    e.n5  = n5[15:0];
    e.n16 = n16[15:0];
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tallies engine activity per packet and scores each pkt_done.
  int   n5_seen, n16_seen;
  logic both_seen, data_bad;
  always @(negedge clk) begin
    if (rst || crc_clear) begin
      n5_seen   = 0;
      n16_seen  = 0;
      both_seen = 1'b0;
      data_bad  = 1'b0;
    end else begin
      n5_seen  += int'(crc5_shift);
      n16_seen += int'(crc16_shift);
      if (crc5_shift && crc16_shift) both_seen = 1'b1;
      if (crc_data !== bit_data)     data_bad  = 1'b1;
    end
    if (!rst && pkt_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("pkt%0d_pid", e.id),      int'(pid),     int'(e.pid));
        check($sformatf("pkt%0d_pkt_ok", e.id),   int'(pkt_ok),  int'(e.ok));
        check($sformatf("pkt%0d_err_pid", e.id),  int'(err_pid), int'(e.ep));
        check($sformatf("pkt%0d_err_len", e.id),  int'(err_len), int'(e.el));
        check($sformatf("pkt%0d_err_crc", e.id),  int'(err_crc), int'(e.ec));
        check($sformatf("pkt%0d_crc5_shifts", e.id),  n5_seen,  int'(e.n5));
        check($sformatf("pkt%0d_crc16_shifts", e.id), n16_seen, int'(e.n16));
        check($sformatf("pkt%0d_both_shift", e.id),   int'(both_seen), 0);
        check($sformatf("pkt%0d_crc_data", e.id),     int'(data_bad),  0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sop(input string name);
    sop = 1'b1;
    @(negedge clk);
    check({name, "_crc_clear_at_sop"}, int'(crc_clear), 1);
    tick();
    sop = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    tick();
    bit_valid = 1'b0;
    bit_data  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic finish_pkt(input exp_t e);
    exp_q.push_back(e);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) tick();
    check($sformatf("pkt%0d_done_seen", e.id), exp_q.size(), 0);
    tick();
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    check({name, "_pid"},         int'(pid),         0);
    check({name, "_pkt_done"},    int'(pkt_done),    0);
    check({name, "_pkt_ok"},      int'(pkt_ok),      0);
    check({name, "_err_pid"},     int'(err_pid),     0);
    check({name, "_err_len"},     int'(err_len),     0);
    check({name, "_err_crc"},     int'(err_crc),     0);
    check({name, "_crc5_shift"},  int'(crc5_shift),  0);
    check({name, "_crc16_shift"}, int'(crc16_shift), 0);
    check({name, "_crc_clear"},   int'(crc_clear),   1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1; sop = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; eop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");
    tick();
    tick();

    // 1: SETUP token, addr 0 endp 0
    do_sop("setup");
    send_byte(8'h2D); send_byte(8'h00); send_byte(8'h10);
    finish_pkt(mk(1, 4'hD, 1, 0, 0, 0, 16, 0));

    // 2: zero-length DATA0
    do_sop("data0");
    send_byte(8'hC3); send_byte(8'h00); send_byte(8'h00);
    finish_pkt(mk(2, 4'h3, 1, 0, 0, 0, 0, 16));

    // 3: same with last CRC bit flipped
    do_sop("data0_bad");
    send_byte(8'hC3); send_byte(8'h00); send_byte(8'h80);
    finish_pkt(mk(3, 4'h3, 0, 0, 0, 1, 0, 16));

    // 4: ACK
    do_sop("ack");
    send_byte(8'hD2);
    finish_pkt(mk(4, 4'h2, 1, 0, 0, 0, 0, 0));

    // 5: ACK plus one stray bit
    do_sop("ack_long");
    send_byte(8'hD2); send_bit(1'b1);
    finish_pkt(mk(5, 4'h2, 0, 0, 1, 0, 0, 0));

    // 6: corrupted PID, rest drained
    do_sop("badpid");
    send_byte(8'hE2); send_byte(8'h55);
    finish_pkt(mk(6, 4'h2, 0, 1, 0, 0, 0, 0));

    // 7: token with 3 extra bits: counted, not shifted
    do_sop("token_long");
    send_byte(8'h2D); send_byte(8'h00); send_byte(8'h10);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    finish_pkt(mk(7, 4'hD, 0, 0, 1, 0, 16, 0));

    // 8: eop while still collecting the PID; pid keeps its last value
    do_sop("pid_short");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    finish_pkt(mk(8, 4'hD, 0, 0, 1, 0, 0, 0));

    // 9: DATA of 30 bits (short and not byte aligned)
    do_sop("data_short");
    send_byte(8'hC3); send_zeros(22);
    finish_pkt(mk(9, 4'h3, 0, 0, 1, 0, 0, 22));

    // 10: DATA of 1064 bits (byte aligned, above maximum)
    do_sop("data_long");
    send_byte(8'hC3); send_zeros(1056);
    finish_pkt(mk(10, 4'h3, 0, 0, 1, 0, 0, 1056));

    // 11: DATA aborted at count 40 by a sop coincident with eop, then ACK
    do_sop("abort");
    @(negedge clk);
    check("abort_flags_cleared_err_len", int'(err_len), 0);
    check("abort_flags_cleared_pkt_ok",  int'(pkt_ok),  0);
    tick();
    send_byte(8'hC3);
    for (int i = 0; i < 4; i++) send_byte(8'hAA);
    eop = 1'b1;
    do_sop("abort_second");
    eop = 1'b0;
    send_byte(8'hD2);
    finish_pkt(mk(11, 4'h2, 1, 0, 0, 0, 0, 0));

    // 12: reset at token bit 12
    do_sop("rst_mid");
    send_byte(8'h2D);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_mid");
    repeat (6) tick();

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_rx_seq.md
CRC_RX_SEQ -- requirements
Module: crc_rx_seq

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sop  in  1  start of packet; SYNC just completed
- bit_valid  in  1  strobe: bit_data holds one decoded bit, LSB-first
- bit_data  in  1  decoded bit
- eop  in  1  end-of-packet strobe
- crc5_valid  in  1  residual match from the CRC5 engine
- crc16_valid  in  1  residual match from the CRC16 engine
- crc_data  out  1  bit fed to both CRC engines
- crc_clear  out  1  preset both engines
- crc5_shift  out  1  shift enable, CRC5 engine
- crc16_shift  out  1  shift enable, CRC16 engine
- pid  out  4  latched PID[3:0]
- pkt_done  out  1  one-cycle completion pulse
- pkt_ok  out  1  packet passed all checks; held until next sop
- err_pid, err_len, err_crc  out  1 each  error flags; held until next sop

Function
REQ-003 SHALL implement states IDLE, PID, TOKEN, DATA, HSK, DRAIN and CHECK.
REQ-004 sop in any state SHALL go to PID, pulse crc_clear for that cycle, zero the 11-bit bit counter, and clear pkt_ok and all err_* flags.
REQ-005 An aborted packet (sop while not IDLE) SHALL NOT produce pkt_done.
REQ-006 crc_data SHALL equal bit_data combinationally in every cycle.
REQ-007 In PID, 8 bit_valid bits SHALL shift into an 8-bit PID register, LSB first. No CRC shift occurs in PID.
REQ-008 After the 8th PID bit: if PID[7:4] != ~PID[3:0], set err_pid and go to DRAIN.
REQ-009 After the 8th PID bit with a valid PID, branch on PID[1:0]: 01 -> TOKEN; 11 -> DATA; 10 -> HSK; 00 -> set err_pid, go to DRAIN.
REQ-010 pid SHALL latch PID[3:0] when the 8th bit arrives.
REQ-011 TOKEN: each bit_valid SHALL assert crc5_shift in the same cycle.
REQ-012 DATA: each bit_valid SHALL assert crc16_shift in the same cycle.
REQ-013 crc5_shift and crc16_shift SHALL never be high together.
REQ-014 The bit counter SHALL count every bit_valid from sop; it saturates at 2047.
REQ-015 eop in PID/TOKEN/DATA/HSK/DRAIN SHALL go to CHECK. A bit_valid coincident with eop is discarded (not counted, not shifted).
REQ-016 CHECK SHALL last exactly one cycle, then go to IDLE with pkt_done high for that cycle.
REQ-017 err_len SHALL set in CHECK if the bit count is wrong for the packet type:
- TOKEN: count != 24
- HSK: count != 8
- DATA: count < 24, count > 1048, or count not a multiple of 8
- PID state at eop: always
REQ-018 err_crc SHALL set in CHECK for TOKEN with crc5_valid=0, or DATA with crc16_valid=0; it is not evaluated if err_len is set.
REQ-019 pkt_ok SHALL be set in CHECK iff no err_* flag is set.
REQ-020 Bits arriving in TOKEN past count 24, or in HSK past count 8, SHALL still be counted but SHALL NOT be shifted into any engine.
REQ-021 DRAIN SHALL ignore bits and only wait for eop or sop.
REQ-022 eop or bit_valid in IDLE SHALL be ignored.
REQ-023 sop coincident with eop SHALL take the sop path.

Reset
REQ-024 rst SHALL force IDLE and zero pid, the counter, pkt_done, pkt_ok and all err_* flags, and deassert all CRC controls, on the next clock edge, including mid-packet.
REQ-025 crc_clear SHALL be asserted in the first cycle after rst deasserts, so both engines start preset.

Verification
REQ-026 SETUP token bytes 2D 00 10 (LSB-first), engine models attached, then eop -> crc5_shift high for 16 cycles, pid=D, pkt_done one cycle after eop, pkt_ok=1.
REQ-027 Zero-length DATA0, bytes C3 00 00 -> 16 crc16_shift pulses, pid=3, pkt_ok=1; same packet with last bit flipped -> err_crc=1, pkt_ok=0.
REQ-028 ACK byte D2 then eop -> no CRC shifts, pkt_ok=1. ACK plus one extra bit -> err_len=1.
REQ-029 PID byte 0xE2 -> err_pid=1, DRAIN until eop, pkt_done pulses, err_len=0, err_crc=0.
REQ-030 sop mid-DATA (count 40) followed by a valid ACK -> exactly one pkt_done, for the ACK, with crc_clear pulsed at both sops.
REQ-031 rst asserted at TOKEN bit 12 -> all outputs 0 next cycle, no pkt_done, crc_clear high in the first post-reset cycle.
